bit_stuff_gen: RTL



---
 rtl/bit_stuff_gen.sv | 126 ++++++++++++
 1 files changed

// File: rtl/bit_stuff_gen.sv
// Serial bit stuffer/unstuffer: inserts (TX) or removes and checks (RX)
// a STUFF_BIT after RUN_LEN consecutive ~STUFF_BIT bits.
module bit_stuff_gen #(
    parameter int   RUN_LEN   = 6,
    parameter logic STUFF_BIT = 1'b0,
    parameter int   CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_L,
    input  logic             start,
    input  logic             dir,
    input  logic             abort,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    output logic             out_bit,
    output logic             out_last,
    output logic             done,
    output logic             stuff_err,
    output logic [CNT_W-1:0] stuff_cnt
);

    localparam int RW = $clog2(RUN_LEN + 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(RUN_LEN);
    localparam logic [RW-1:0] RUN_PRE = RW'(RUN_LEN - 1);

    typedef enum logic [1:0] {IDLE, RUN, STUFF, FLUSH} state_t;

    state_t           state;
    logic             rx;
    logic             last_pend;
    logic [RW-1:0]    run;
    logic             accept;
    logic             mark;
    logic             run_full;
    logic [CNT_W-1:0] cnt_inc;

    assign in_ready = (state == RUN);
    assign accept   = in_valid & in_ready;
    assign mark     = (in_bit != STUFF_BIT);
    assign run_full = (run == RUN_MAX);
    // Saturating stuff-event counter
    assign cnt_inc  = (&stuff_cnt) ? stuff_cnt : stuff_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state     <= IDLE;
            rx        <= 1'b0;
            last_pend <= 1'b0;
            run       <= '0;
            stuff_cnt <= '0;
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            stuff_err <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            stuff_err <= 1'b0;
            if (abort && state != IDLE) begin
                state     <= IDLE;
                run       <= '0;
                last_pend <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            state     <= RUN;
                            rx        <= dir;
                            run       <= '0;
                            stuff_cnt <= '0;
                            last_pend <= 1'b0;
                        end
                    end
                    RUN: begin
                        if (accept) begin
                            if (rx && run_full) begin
                                run <= '0;
                                if (mark) begin
                                    stuff_err <= 1'b1;
                                    state     <= IDLE;
                                end else begin
                                    stuff_cnt <= cnt_inc;
                                    if (in_last) begin
                                        done  <= 1'b1;
                                        state <= FLUSH;
                                    end
                                end
                            end else begin
                                out_valid <= 1'b1;
                                out_bit   <= in_bit;
                                run       <= mark ? run + 1'b1 : '0;
                                // TX run just completed: insert stuff bit next
                                if (!rx && mark && run == RUN_PRE) begin
                                    state     <= STUFF;
                                    run       <= '0;
                                    last_pend <= in_last;
                                end else if (in_last) begin
                                    out_last <= 1'b1;
                                    done     <= 1'b1;
                                    state    <= FLUSH;
                                end
                            end
                        end
                    end
                    STUFF: begin
                        out_valid <= 1'b1;
                        out_bit   <= STUFF_BIT;
                        out_last  <= last_pend;
                        done      <= last_pend;
                        stuff_cnt <= cnt_inc;
                        last_pend <= 1'b0;
                        state     <= last_pend ? FLUSH : RUN;
                    end
                    FLUSH: state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
